// File: rtl/mem_dp_pkg.sv
// Shared types and helpers for the mem_dp simple-dual-port RAM family.
package mem_dp_pkg;

    typedef enum logic {CLEAR, READY} state_t;

    localparam int MAX_DATA_W = 1024;
    localparam int MAX_LANES  = MAX_DATA_W / 8;

    function automatic int nlanes(input int data_w);
        return data_w / 8;
    endfunction

    // Even parity per byte lane; lanes at or beyond data_w/8 read as zero.
    function automatic logic [MAX_LANES-1:0] lane_parity(input logic [MAX_DATA_W-1:0] d,
                                                         input int data_w);
        logic [MAX_LANES-1:0] p;
        p = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < nlanes(data_w)) begin
                p[i] = ^d[i*8 +: 8];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mem_dp_array.sv
// Lane-split storage array: one write port with per-lane enables, unregistered read port.
module mem_dp_array #(
    parameter int LANES  = 8,
    parameter int LANE_W = 8,
    parameter int DEPTH  = 2048,
    parameter int IDX_W  = 11
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [IDX_W-1:0]        waddr,
    input  logic [LANES-1:0]        lane_en,
    input  logic [LANES*LANE_W-1:0] wdata,
    input  logic [IDX_W-1:0]        raddr,
    output logic [LANES*LANE_W-1:0] rdata
);

    // One array per lane keeps each lane's write enable a plain RAM write enable.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [LANE_W-1:0] mem [DEPTH];

            always_ff @(posedge clk) begin
                if (we && lane_en[gi]) begin
                    mem[waddr] <= wdata[gi*LANE_W +: LANE_W];
                end
            end

            assign rdata[gi*LANE_W +: LANE_W] = mem[raddr];
        end
    endgenerate

endmodule

// File: rtl/mem_dp_ram.sv
// Simple-dual-port RAM with byte enables, write-first forwarding, q_valid and post-reset clear.
// Optional lane parity (par_inject/par_err ports) when MEM_DP_PARITY_EN is defined.
module mem_dp_ram
    import mem_dp_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 11,
    parameter int DEPTH      = 2048,
    parameter int OUT_REG    = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic                  clock,
    input  logic                  aclr,
    output logic                  init_busy,
    input  logic                  wren,
    input  logic [ADDR_W-1:0]     wraddress,
    input  logic [DATA_W-1:0]     data,
    input  logic [DATA_W/8-1:0]   byteena,
    input  logic                  rden,
    input  logic [ADDR_W-1:0]     rdaddress,
    output logic [DATA_W-1:0]     q,
    output logic                  q_valid
`ifdef MEM_DP_PARITY_EN
    ,
    input  logic                  par_inject,
    output logic                  par_err
`endif
);

    localparam int LANES = nlanes(DATA_W);
`ifdef MEM_DP_PARITY_EN
    localparam int LANE_W = 9;
`else
    localparam int LANE_W = 8;
`endif
    localparam int WORD_W = LANES * LANE_W;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_V  = (ADDR_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t            state_reg;
    logic [IDX_W-1:0]  clr_addr_reg;
    logic              init_busy_reg;
    logic              rd_v1_reg;
    logic [DATA_W-1:0] rd_d1_reg;

    logic              clearing, wr_accept, rd_accept, rd_in_range, fwd_hit, arr_we;
    logic [IDX_W-1:0]  arr_waddr;
    logic [LANES-1:0]  arr_lane_en;
    logic [WORD_W-1:0] wr_word, arr_wdata, rd_word, merged_word;
    logic [DATA_W-1:0] rd_data_c;

    assign clearing    = (state_reg == CLEAR);
    assign wr_accept   = !clearing && wren && ({1'b0, wraddress} < DEPTH_V);
    assign rd_accept   = !clearing && rden;
    assign rd_in_range = ({1'b0, rdaddress} < DEPTH_V);
    assign fwd_hit     = wr_accept && (wraddress == rdaddress);

`ifdef MEM_DP_PARITY_EN
    logic [LANES-1:0] wr_par, rd_par_stored, rd_par_calc;
    logic             rd_perr_c, rd_e1_reg;

    assign wr_par      = LANES'(lane_parity(MAX_DATA_W'(data), DATA_W)) ^ LANES'(par_inject);
    assign rd_par_calc = LANES'(lane_parity(MAX_DATA_W'(rd_data_c), DATA_W));
    assign rd_perr_c   = |(rd_par_stored ^ rd_par_calc);
`endif

    // Merge same-cycle write data into the read word so the result does not
    // depend on the RAM primitive's own read-during-write behaviour.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
`ifdef MEM_DP_PARITY_EN
            assign wr_word[gi*LANE_W +: LANE_W] = {wr_par[gi], data[gi*8 +: 8]};
            assign rd_par_stored[gi]            = merged_word[gi*LANE_W + 8];
`else
            assign wr_word[gi*LANE_W +: LANE_W] = data[gi*8 +: 8];
`endif
            assign merged_word[gi*LANE_W +: LANE_W] = (fwd_hit && byteena[gi]) ?
                wr_word[gi*LANE_W +: LANE_W] : rd_word[gi*LANE_W +: LANE_W];
            assign rd_data_c[gi*8 +: 8] = merged_word[gi*LANE_W +: 8];
        end
    endgenerate

    assign arr_we      = clearing || (wr_accept && (|byteena));
    assign arr_waddr   = clearing ? clr_addr_reg : wraddress[IDX_W-1:0];
    assign arr_lane_en = clearing ? '1 : byteena;
    assign arr_wdata   = clearing ? '0 : wr_word;

    mem_dp_array #(
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clock),
        .we      (arr_we),
        .waddr   (arr_waddr),
        .lane_en (arr_lane_en),
        .wdata   (arr_wdata),
        .raddr   (rdaddress[IDX_W-1:0]),
        .rdata   (rd_word)
    );

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state_reg     <= (INIT_CLEAR != 0) ? CLEAR : READY;
            clr_addr_reg  <= '0;
            init_busy_reg <= (INIT_CLEAR != 0);
        end else if (state_reg == CLEAR) begin
            if (clr_addr_reg == LAST_IDX) begin
                state_reg     <= READY;
                init_busy_reg <= 1'b0;
            end else begin
                clr_addr_reg <= clr_addr_reg + 1'b1;
            end
        end
    end

    assign init_busy = init_busy_reg;

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            rd_v1_reg <= 1'b0;
            rd_d1_reg <= '0;
        end else begin
            rd_v1_reg <= rd_accept;
            if (rd_accept) begin
                rd_d1_reg <= rd_in_range ? rd_data_c : '0;
            end
        end
    end

`ifdef MEM_DP_PARITY_EN
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            rd_e1_reg <= 1'b0;
        end else begin
            rd_e1_reg <= rd_accept && rd_in_range && rd_perr_c;
        end
    end
`endif

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] q_reg;
            logic              q_valid_reg;

            always_ff @(posedge clock or posedge aclr) begin
                if (aclr) begin
                    q_reg       <= '0;
                    q_valid_reg <= 1'b0;
                end else begin
                    q_valid_reg <= rd_v1_reg;
                    if (rd_v1_reg) begin
                        q_reg <= rd_d1_reg;
                    end
                end
            end

            assign q       = q_reg;
            assign q_valid = q_valid_reg;
`ifdef MEM_DP_PARITY_EN
            logic par_err_reg;

            always_ff @(posedge clock or posedge aclr) begin
                if (aclr) begin
                    par_err_reg <= 1'b0;
                end else begin
                    par_err_reg <= rd_e1_reg;
                end
            end

            assign par_err = par_err_reg;
`endif
        end else begin : g_no_out_reg
            assign q       = rd_d1_reg;
            assign q_valid = rd_v1_reg;
`ifdef MEM_DP_PARITY_EN
            assign par_err = rd_e1_reg;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_mem_dp_ram.sv
// Randomised self-checking bench for mem_dp_ram (DEPTH=16, OUT_REG=1, INIT_CLEAR=1).
// Define MEM_DP_PARITY_EN to also exercise the parity ports.
module tb_mem_dp_ram;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 16;
    localparam int LANES  = DATA_W / 8;

    logic              clock = 1'b0;
    logic              aclr = 1'b1;
    logic              init_busy;
    logic              wren = 1'b0;
    logic [ADDR_W-1:0] wraddress = '0;
    logic [DATA_W-1:0] data = '0;
    logic [LANES-1:0]  byteena = '0;
    logic              rden = 1'b0;
    logic [ADDR_W-1:0] rdaddress = '0;
    logic [DATA_W-1:0] q;
    logic              q_valid;
`ifdef MEM_DP_PARITY_EN
    logic              par_inject = 1'b0;
    logic              par_err;
`endif

    always #5 clock = ~clock;

    mem_dp_ram #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .OUT_REG    (1),
        .INIT_CLEAR (1)
    ) dut (
        .clock      (clock),
        .aclr       (aclr),
        .init_busy  (init_busy),
        .wren       (wren),
        .wraddress  (wraddress),
        .data       (data),
        .byteena    (byteena),
        .rden       (rden),
        .rdaddress  (rdaddress),
        .q          (q),
        .q_valid    (q_valid)
`ifdef MEM_DP_PARITY_EN
        ,
        .par_inject (par_inject),
        .par_err    (par_err)
`endif
    );

    // Reference model: word array, lane-0 parity-corruption flag, queue of reads due at an edge.
    typedef struct {
        int                due;
        logic [DATA_W-1:0] val;
        logic              perr;
    } rd_t;

    rd_t               pend[$];
    logic [DATA_W-1:0] mem_m [DEPTH];
    logic              perr_m [DEPTH];
    int                clear_left = 0;
    int                edge_cnt = 0;
    logic              exp_v = 1'b0;
    logic              exp_e = 1'b0;
    logic              exp_busy = 1'b1;
    logic [DATA_W-1:0] exp_q = '0;
    int                checks = 0;
    int                errors = 0;

    task automatic model_reset();
        pend.delete();
        clear_left = DEPTH;
        exp_v      = 1'b0;
        exp_e      = 1'b0;
        exp_q      = '0;
        exp_busy   = 1'b1;
    endtask

    // Drive one cycle from a negedge, advance the model at the posedge, return at the next negedge.
    task automatic drive(input logic w, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] d,
                         input logic [LANES-1:0] be, input logic inj,
                         input logic r, input logic [ADDR_W-1:0] ra);
        rd_t rd;
        int  widx;
        int  ridx;
        wren = w; wraddress = wa; data = d; byteena = be; rden = r; rdaddress = ra;
`ifdef MEM_DP_PARITY_EN
        par_inject = inj;
`endif
        widx = int'(wa);
        ridx = int'(ra);
        @(posedge clock);
        edge_cnt++;
        if (clear_left > 0) begin
            mem_m[DEPTH - clear_left]  = '0;
            perr_m[DEPTH - clear_left] = 1'b0;
            clear_left--;
        end else begin
            if (w && widx < DEPTH) begin
                for (int i = 0; i < LANES; i++) begin
                    if (be[i]) mem_m[widx][i*8 +: 8] = d[i*8 +: 8];
                end
                if (be[0]) perr_m[widx] = inj;
            end
            if (r) begin
                rd.due  = edge_cnt + 1;
                rd.val  = (ridx < DEPTH) ? mem_m[ridx] : '0;
                rd.perr = (ridx < DEPTH) ? perr_m[ridx] : 1'b0;
                pend.push_back(rd);
            end
        end
        exp_v = 1'b0;
        exp_e = 1'b0;
        if (pend.size() > 0 && pend[0].due == edge_cnt) begin
            rd    = pend.pop_front();
            exp_v = 1'b1;
            exp_q = rd.val;
            exp_e = rd.perr;
        end
        exp_busy = (clear_left > 0);
        @(negedge clock);
    endtask

    task automatic test_reset();
        int busy_cnt = 0;
        aclr = 1'b1;
        repeat (3) begin
            @(negedge clock);
            checks++;
            if (q !== '0 || q_valid !== 1'b0 || init_busy !== 1'b1) begin
                errors++;
                $display("FAIL reset_state: q=%h q_valid=%b init_busy=%b, expected 0/0/1",
                         q, q_valid, init_busy);
            end
        end
        aclr = 1'b0;
        model_reset();
        for (int c = 0; c < 20; c++) begin
            if (init_busy === 1'b1) busy_cnt++;
            checks++;
            if (init_busy !== exp_busy || q_valid !== 1'b0) begin
                errors++;
                $display("FAIL clear_sweep c%0d: init_busy=%b q_valid=%b, expected %b/0",
                         c, init_busy, q_valid, exp_busy);
            end
            drive(exp_busy, ADDR_W'($urandom_range(0, DEPTH-1)), {$urandom, $urandom}, 8'hFF, 1'b0,
                  exp_busy, ADDR_W'($urandom_range(0, DEPTH-1)));
        end
        checks++;
        if (busy_cnt != DEPTH) begin
            errors++;
            $display("FAIL clear_len: init_busy high %0d cycles, expected %0d", busy_cnt, DEPTH);
        end
        for (int c = 0; c < DEPTH + 2; c++) begin
            drive(1'b0, '0, '0, '0, 1'b0, c < DEPTH, ADDR_W'(c % DEPTH));
            checks++;
            if (q_valid !== exp_v || q !== exp_q || (exp_v && q !== '0)) begin
                errors++;
                $display("FAIL clear_readback c%0d: q_valid=%b q=%h, expected q_valid=%b q=%h",
                         c, q_valid, q, exp_v, exp_q);
            end
        end
    endtask

    task automatic test_write_read();
        logic [DATA_W-1:0] val = 64'h1122334455667788;
        drive(1'b1, 5, val, 8'hFF, 1'b0, 1'b0, '0);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 5);
        checks++;
        if (q_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: q_valid=%b one edge after rden, expected 0", q_valid);
        end
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
        checks++;
        if (q_valid !== 1'b1 || q !== val) begin
            errors++;
            $display("FAIL write_read: q_valid=%b q=%h, expected 1 %h", q_valid, q, val);
        end
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
        checks++;
        if (q_valid !== 1'b0 || q !== val) begin
            errors++;
            $display("FAIL q_hold: q_valid=%b q=%h, expected 0 %h", q_valid, q, val);
        end
    endtask

    task automatic test_rdw();
        logic [DATA_W-1:0] merged = 64'h11223344AAAAAAAA;
        drive(1'b1, 5, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b0, 1'b1, 5);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
        checks++;
        if (q_valid !== 1'b1 || q !== merged) begin
            errors++;
            $display("FAIL rdw_merge: q_valid=%b q=%h, expected 1 %h", q_valid, q, merged);
        end
        drive(1'b1, 5, 64'hFFFFFFFFFFFFFFFF, 8'h00, 1'b0, 1'b1, 5);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
        checks++;
        if (q_valid !== 1'b1 || q !== merged) begin
            errors++;
            $display("FAIL byteena_zero: q_valid=%b q=%h, expected 1 %h", q_valid, q, merged);
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] wvals [8];
        int pulses = 0;
        for (int i = 0; i < 8; i++) begin
            wvals[i] = {$urandom, $urandom};
            drive(1'b1, ADDR_W'(8 + i), wvals[i], 8'hFF, 1'b0, 1'b0, '0);
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, '0, '0, '0, 1'b0, i < 8, ADDR_W'(8 + (i % 8)));
            if (q_valid === 1'b1) pulses++;
            checks++;
            if (q_valid !== (i >= 1 && i <= 8) || (i >= 1 && i <= 8 && q !== wvals[i-1])) begin
                errors++;
                $display("FAIL back_to_back i%0d: q_valid=%b q=%h, expected q_valid=%b q=%h",
                         i, q_valid, q, (i >= 1 && i <= 8), wvals[(i + 7) % 8]);
            end
        end
        checks++;
        if (pulses != 8) begin
            errors++;
            $display("FAIL b2b_pulses: %0d q_valid pulses, expected 8", pulses);
        end
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 20);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
        checks++;
        if (q_valid !== 1'b1 || q !== '0) begin
            errors++;
            $display("FAIL out_of_range_read: q_valid=%b q=%h, expected 1 0", q_valid, q);
        end
`ifdef MEM_DP_PARITY_EN
        checks++;
        if (par_err !== 1'b0) begin
            errors++;
            $display("FAIL out_of_range_par: par_err=%b, expected 0", par_err);
        end
`endif
    endtask

    task automatic test_mid_reset();
        int busy_cnt = 0;
        aclr = 1'b1;
        @(negedge clock);
        aclr = 1'b0;
        model_reset();
        repeat (7) drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
        checks++;
        if (init_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_sweep_busy: init_busy=%b, expected 1", init_busy);
        end
        aclr = 1'b1;
        repeat (2) @(negedge clock);
        aclr = 1'b0;
        model_reset();
        for (int c = 0; c < 20; c++) begin
            if (init_busy === 1'b1) busy_cnt++;
            drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
        end
        checks++;
        if (busy_cnt != DEPTH) begin
            errors++;
            $display("FAIL sweep_restart: init_busy high %0d cycles, expected %0d", busy_cnt, DEPTH);
        end
        drive(1'b1, 4, 64'hDEADBEEFCAFEF00D, 8'hFF, 1'b0, 1'b0, '0);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 4);
        rden = 1'b1;
        rdaddress = 4;
        #2;
        aclr = 1'b1;
        repeat (3) begin
            @(negedge clock);
            rden = 1'b0;
            checks++;
            if (q_valid !== 1'b0 || q !== '0) begin
                errors++;
                $display("FAIL inflight_drop: q_valid=%b q=%h, expected 0 0", q_valid, q);
            end
        end
        aclr = 1'b0;
        model_reset();
        busy_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (init_busy === 1'b1) busy_cnt++;
            checks++;
            if (q_valid !== 1'b0) begin
                errors++;
                $display("FAIL inflight_after_reset c%0d: q_valid=%b, expected 0", c, q_valid);
            end
            drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
        end
        checks++;
        if (busy_cnt != DEPTH) begin
            errors++;
            $display("FAIL sweep_after_inflight: init_busy high %0d cycles, expected %0d",
                     busy_cnt, DEPTH);
        end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] wa, ra;
        logic [LANES-1:0]  be;
        for (int c = 0; c < 400; c++) begin
            wa = ADDR_W'($urandom_range(0, DEPTH + 3));
            ra = ($urandom_range(0, 3) == 0) ? wa : ADDR_W'($urandom_range(0, DEPTH + 3));
            be = ($urandom_range(0, 7) == 0) ? '0 : LANES'($urandom);
            drive($urandom_range(0, 1) == 1, wa, {$urandom, $urandom}, be,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, ra);
            checks++;
            if (q_valid !== exp_v || q !== exp_q) begin
                errors++;
                $display("FAIL random c%0d: q_valid=%b q=%h, expected q_valid=%b q=%h",
                         c, q_valid, q, exp_v, exp_q);
            end
`ifdef MEM_DP_PARITY_EN
            checks++;
            if (par_err !== exp_e) begin
                errors++;
                $display("FAIL random_par c%0d: par_err=%b, expected %b", c, par_err, exp_e);
            end
`endif
        end
    endtask

`ifdef MEM_DP_PARITY_EN
    task automatic test_parity();
        drive(1'b1, 3, {$urandom, $urandom}, 8'hFF, 1'b1, 1'b0, '0);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 3);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
        checks++;
        if (q_valid !== 1'b1 || par_err !== 1'b1) begin
            errors++;
            $display("FAIL parity_inject: q_valid=%b par_err=%b, expected 1 1", q_valid, par_err);
        end
        drive(1'b1, 3, {$urandom, $urandom}, 8'hFF, 1'b0, 1'b0, '0);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 3);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
        checks++;
        if (q_valid !== 1'b1 || par_err !== 1'b0) begin
            errors++;
            $display("FAIL parity_clean: q_valid=%b par_err=%b, expected 1 0", q_valid, par_err);
        end
        drive(1'b1, 3, {$urandom, $urandom}, 8'hFF, 1'b1, 1'b1, 3);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
        checks++;
        if (q_valid !== 1'b1 || par_err !== 1'b1) begin
            errors++;
            $display("FAIL parity_forward: q_valid=%b par_err=%b, expected 1 1", q_valid, par_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_rdw();
        test_back_to_back();
        test_mid_reset();
        test_random();
`ifdef MEM_DP_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
